// File: rtl/usrt_tx_arb.sv
// usrt_tx_arb: two-requester round-robin front end for a synchronous serial
// transmitter. A granted byte is loaded into an external 8-bit data register
// (reg_ld/reg_d) and then shifted out LSB first from reg_q. Each frame is one
// start bit, eight data bits and STOP_BITS stop bits. One line bit lasts one
// bit_en period.
//
// Handshake: a requester raises reqN with dataN stable and keeps both until
// gntN. The byte moves in the single cycle where gntN is high. gnt is only
// issued in IDLE, so a request raised while busy simply waits. A req still
// high after its gnt is treated as the next byte.
module usrt_tx_arb #(
    parameter int STOP_BITS = 1 // legal values: 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    input  logic       bit_en,
    output logic       reg_ld,
    output logic [7:0] reg_d,
    input  logic [7:0] reg_q,
    output logic       txd,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    state_t     state_q;
    logic [2:0] idx_q;
    logic [1:0] stop_cnt_q;
    logic       txd_q;
    logic       prio1_q;   // 1: requester 1 wins the next tie
    logic [7:0] reg_d_q;   // last byte driven on reg_d

    logic       is_idle;
    logic       any_req;
    logic       pick1;
    logic       grant;
    logic [7:0] grant_data;

    // Arbitration and grant decode; rst blocks any grant in the same cycle.
    always_comb begin
        is_idle    = (state_q == S_IDLE);
        any_req    = req0 | req1;
        pick1      = req1 & (~req0 | prio1_q);
        grant      = ~rst & is_idle & any_req;
        grant_data = pick1 ? data1 : data0;
        gnt0       = grant & ~pick1;
        gnt1       = grant & pick1;
        reg_ld     = grant;
        if (rst) begin
            reg_d = 8'h00;
        end else if (grant) begin
            reg_d = grant_data;
        end else begin
            reg_d = reg_d_q;
        end
    end

    assign txd         = txd_q;
    assign busy        = ~is_idle;
    assign dbg_state_o = state_q;

    // Frame sequencer: txd changes on the same edge as the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            stop_cnt_q <= 2'd0;
            txd_q      <= 1'b1;
            prio1_q    <= 1'b0;
            reg_d_q    <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    // bit_en is ignored here, including in the grant cycle.
                    if (any_req) begin
                        state_q <= S_LOAD;
                        prio1_q <= ~pick1;
                        reg_d_q <= grant_data;
                    end
                end
                S_LOAD: begin
                    if (bit_en) begin
                        state_q <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_en) begin
                        state_q <= S_DATA;
                        idx_q   <= 3'd0;
                        txd_q   <= reg_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_en) begin
                        if (idx_q != 3'd7) begin
                            idx_q <= idx_q + 3'd1;
                            txd_q <= reg_q[idx_q + 3'd1];
                        end else begin
                            state_q    <= S_STOP;
                            stop_cnt_q <= 2'd0;
                            txd_q      <= 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    txd_q <= 1'b1;
                    if (bit_en) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            state_q    <= S_IDLE;
                            stop_cnt_q <= 2'd0;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx_arb.sv
// Bench for usrt_tx_arb. Two instances run side by side: index 0 has
// STOP_BITS=1 and index 1 has STOP_BITS=2. They share clk, rst and bit_en,
// and each has its own requesters. The reference model treats a granted byte
// as a queue of line bits {start, d0..d7, stop x S}. After the grant cycle,
// each bit_en pops the next bit, and the bit_en that finds the queue empty
// returns the line to idle.
module tb_usrt_tx_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       bit_en;
    logic       req0_s   [2];
    logic       req1_s   [2];
    logic       gnt0_s   [2];
    logic       gnt1_s   [2];
    logic       reg_ld_s [2];
    logic       txd_s    [2];
    logic       busy_s   [2];
    logic [7:0] data0_s  [2];
    logic [7:0] data1_s  [2];
    logic [7:0] reg_d_s  [2];
    logic [7:0] reg_q_s  [2];
    logic [2:0] state_s  [2];

    usrt_tx_arb #(.STOP_BITS(1)) u_dut_s1 (
        .clk(clk), .rst(rst),
        .req0(req0_s[0]), .data0(data0_s[0]), .gnt0(gnt0_s[0]),
        .req1(req1_s[0]), .data1(data1_s[0]), .gnt1(gnt1_s[0]),
        .bit_en(bit_en), .reg_ld(reg_ld_s[0]), .reg_d(reg_d_s[0]),
        .reg_q(reg_q_s[0]), .txd(txd_s[0]), .busy(busy_s[0]),
        .dbg_state_o(state_s[0])
    );

    usrt_tx_arb #(.STOP_BITS(2)) u_dut_s2 (
        .clk(clk), .rst(rst),
        .req0(req0_s[1]), .data0(data0_s[1]), .gnt0(gnt0_s[1]),
        .req1(req1_s[1]), .data1(data1_s[1]), .gnt1(gnt1_s[1]),
        .bit_en(bit_en), .reg_ld(reg_ld_s[1]), .reg_d(reg_d_s[1]),
        .reg_q(reg_q_s[1]), .txd(txd_s[1]), .busy(busy_s[1]),
        .dbg_state_o(state_s[1])
    );

    // External shared data register for each instance.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reg_ld_s[k]) reg_q_s[k] <= reg_d_s[k];
        end
    end

    // Requester byte queues: index 2*k + r is requester r of instance k.
    logic [7:0] rq [4][$];
    // Reference model state.
    logic       exp_q  [2][$];
    logic       busy_m [2];
    logic       line_m [2];
    int         last_m [2];
    logic [7:0] regd_m [2];
    int         n_vec;
    int         n_err;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s inst%0d observed %02h expected %02h", tag, k, obs, exp);
        end
    endtask

    function automatic bit pending();
        return busy_m[0] || busy_m[1] || rq[0].size() != 0 || rq[1].size() != 0 ||
               rq[2].size() != 0 || rq[3].size() != 0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic be);
        logic       r0, r1, g, win;
        logic [7:0] gd;
        bit_en = be;
        for (int k = 0; k < 2; k++) begin
            req0_s[k]  = (rq[2*k].size() != 0);
            data0_s[k] = req0_s[k] ? rq[2*k][0] : 8'($urandom);
            req1_s[k]  = (rq[2*k+1].size() != 0);
            data1_s[k] = req1_s[k] ? rq[2*k+1][0] : 8'($urandom);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            r0  = (rq[2*k].size() != 0);
            r1  = (rq[2*k+1].size() != 0);
            g   = !rst && !busy_m[k] && (r0 || r1);
            win = (r0 && r1) ? (last_m[k] == 0) : r1;
            gd  = 8'h00;
            if (g) gd = win ? rq[2*k+1][0] : rq[2*k][0];
            chk("gnt0", k, 8'(gnt0_s[k]), 8'(g && !win));
            chk("gnt1", k, 8'(gnt1_s[k]), 8'(g && win));
            chk("reg_ld", k, 8'(reg_ld_s[k]), 8'(g));
            chk("reg_d", k, reg_d_s[k], rst ? 8'h00 : (g ? gd : regd_m[k]));
            chk("txd", k, 8'(txd_s[k]), 8'(line_m[k]));
            chk("busy", k, 8'(busy_s[k]), 8'(busy_m[k]));
            if (rst) begin
                busy_m[k] = 1'b0;
                line_m[k] = 1'b1;
                last_m[k] = 1;
                regd_m[k] = 8'h00;
                exp_q[k].delete();
            end else if (g) begin
                busy_m[k] = 1'b1;
                line_m[k] = 1'b1;
                exp_q[k].delete();
                exp_q[k].push_back(1'b0);
                for (int i = 0; i < 8; i++) exp_q[k].push_back(gd[i]);
                for (int s = 0; s <= k; s++) exp_q[k].push_back(1'b1);
                last_m[k] = win ? 1 : 0;
                regd_m[k] = gd;
                void'(rq[2*k + (win ? 1 : 0)].pop_front());
            end else if (busy_m[k] && be) begin
                if (exp_q[k].size() != 0) begin
                    line_m[k] = exp_q[k].pop_front();
                end else begin
                    busy_m[k] = 1'b0;
                    line_m[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step($urandom_range(0, 2) == 0);
            n++;
        end
        if (pending()) begin
            n_vec++;
            n_err++;
            $error("FAIL timeout waiting for idle: state0=%0d state1=%0d", state_s[0], state_s[1]);
        end
    endtask

    logic [9:0] a5_line;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        a5_line = 10'b11_0100_1010; // line bits in time order, bit 0 first
        rst     = 1'b1;
        bit_en  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req0_s[k] = 1'b0; req1_s[k] = 1'b0;
            data0_s[k] = 8'h00; data1_s[k] = 8'h00;
            busy_m[k] = 1'b0; line_m[k] = 1'b1; last_m[k] = 1; regd_m[k] = 8'h00;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Reset state, including a pending request and bit_en held off by rst.
        rq[0].push_back(8'h5A);
        step(1'b1);
        step(1'b0);
        rst = 1'b0;
        run_idle(400);

        // Single byte A5 with bit_en high in the grant cycle.
        rq[0].push_back(8'hA5);
        step(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            chk("a5_line", 0, 8'(txd_s[0]), 8'(a5_line[i]));
        end
        step(1'b1);
        chk("a5_idle", 0, 8'(busy_s[0]), 8'h00);

        // Two stop bits carrying 8'h00.
        rq[2].push_back(8'h00);
        step(1'b0);
        for (int i = 0; i < 11; i++) begin
            step(1'b1);
            chk("sb2_line", 1, 8'(txd_s[1]), (i < 9) ? 8'h00 : 8'h01);
        end
        step(1'b1);
        chk("sb2_idle", 1, 8'(busy_s[1]), 8'h00);

        // Tie sequence on both instances.
        for (int k = 0; k < 2; k++) begin
            rq[2*k].push_back(8'h11);   rq[2*k].push_back(8'h11);
            rq[2*k+1].push_back(8'h22); rq[2*k+1].push_back(8'h22);
        end
        run_idle(2000);

        // Busy hold-off: requester 1 arrives during data bit 3.
        rq[0].push_back(8'h96);
        step(1'b0);
        repeat (5) step(1'b1);
        rq[1].push_back(8'h4B);
        run_idle(1000);

        // Reset during data bit 5, then a fresh byte from requester 1, then a tie.
        rq[0].push_back(8'hC7);
        step(1'b0);
        repeat (7) step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        chk("rst_txd", 0, 8'(txd_s[0]), 8'h01);
        chk("rst_busy", 0, 8'(busy_s[0]), 8'h00);
        rq[1].push_back(8'h3C);
        run_idle(1000);
        rq[0].push_back(8'h0F);
        rq[1].push_back(8'hF0);
        run_idle(1000);

        // Randomized traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            int q;
            q = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0 && rq[q].size() < 2) rq[q].push_back(8'($urandom));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step($urandom_range(0, 2) == 0);
            rst = 1'b0;
        end
        run_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
